// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus for regfile_wb_arbiter.
// Holds the ALU stream, the LSU valid/ready stream, the register-file write
// port and the status outputs for hazard detection.
// Handshake: an LSU result transfers on a rising clk edge where
// i_lsu_valid && o_lsu_ready. While o_lsu_ready is low, the source holds dest/data.
// The ALU stream has no ready. When o_stall_alu is high, the ALU result is ignored
// and upstream re-presents it in the next cycle.
interface regfile_wb_arbiter_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          i_alu_valid;
    logic [4:0]    i_alu_dest;
    logic [31:0]   i_alu_data;
    logic          i_lsu_valid;
    logic          o_lsu_ready;
    logic [4:0]    i_lsu_dest;
    logic [31:0]   i_lsu_data;
    logic          o_wr_en;
    logic [4:0]    o_dest_addr;
    logic [31:0]   o_data;
    logic          o_stall_alu;
    logic [31:0]   o_busy_mask;
    logic [CW-1:0] o_fifo_count;

    // Upstream pipeline / testbench side
    modport master (
        output i_alu_valid, i_alu_dest, i_alu_data,
        output i_lsu_valid, i_lsu_dest, i_lsu_data,
        input  o_lsu_ready, o_wr_en, o_dest_addr, o_data,
        input  o_stall_alu, o_busy_mask, o_fifo_count
    );

    // Arbiter side
    modport slave (
        input  i_alu_valid, i_alu_dest, i_alu_data,
        input  i_lsu_valid, i_lsu_dest, i_lsu_data,
        output o_lsu_ready, o_wr_en, o_dest_addr, o_data,
        output o_stall_alu, o_busy_mask, o_fifo_count
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter.
// Merges the fixed-timing ALU stream and the handshaked long-latency
// (LSU/mul) stream onto one registered write port.
// Long-latency results are buffered in a DEPTH-entry FIFO.
// A defer counter bounds how long the FIFO head can be starved. When the
// counter saturates, the ALU stream is frozen for one cycle.
// Optional macro WB_LSU_BYPASS_EN: when the FIFO is empty and the ALU is idle,
// an LSU result is written directly with one cycle of latency.
module regfile_wb_arbiter #(
    parameter int DEPTH     = 4,
    parameter int MAX_DEFER = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    regfile_wb_arbiter_if.slave   bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = $clog2(MAX_DEFER + 1);

    logic [4:0]    mem_dest_q [DEPTH];
    logic [31:0]   mem_data_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] defer_q, defer_d;
    logic          wr_en_q, wr_en_d;
    logic [4:0]    dest_q, dest_d;
    logic [31:0]   data_q, data_d;

    logic          fifo_empty;
    logic          fifo_full;
    logic          stall;
    logic          byp_ok;
    logic          push;
    logic          pop;
    logic          sel_v;
    logic [4:0]    sel_dest;
    logic [31:0]   sel_data;
    logic [31:0]   busy_mask;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(DEPTH));
    assign stall      = (defer_q == DW'(MAX_DEFER)) && !fifo_empty;

`ifdef WB_LSU_BYPASS_EN
    // A result may skip the FIFO only when nothing is queued ahead of it.
    // This keeps write order intact.
    assign byp_ok = fifo_empty && !bus.i_alu_valid && bus.i_lsu_valid;
`else
    assign byp_ok = 1'b0;
`endif

    // Pick the write source: forced pop, then ALU, then bypass, then FIFO head.
    always_comb begin
        pop      = 1'b0;
        sel_v    = 1'b0;
        sel_dest = '0;
        sel_data = '0;
        if (stall) begin
            pop      = 1'b1;
            sel_v    = 1'b1;
            sel_dest = mem_dest_q[rd_ptr_q];
            sel_data = mem_data_q[rd_ptr_q];
        end else if (bus.i_alu_valid) begin
            sel_v    = 1'b1;
            sel_dest = bus.i_alu_dest;
            sel_data = bus.i_alu_data;
        end else if (byp_ok) begin
            sel_v    = 1'b1;
            sel_dest = bus.i_lsu_dest;
            sel_data = bus.i_lsu_data;
        end else if (!fifo_empty) begin
            pop      = 1'b1;
            sel_v    = 1'b1;
            sel_dest = mem_dest_q[rd_ptr_q];
            sel_data = mem_data_q[rd_ptr_q];
        end
    end

    // Compute the next state of the output register, FIFO pointers and defer counter.
    // A full FIFO refuses pushes even when it pops in the same cycle.
    always_comb begin
        push     = bus.i_lsu_valid && !fifo_full && !byp_ok;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (fifo_empty || pop) begin
            defer_d = '0;
        end else if (defer_q != DW'(MAX_DEFER)) begin
            defer_d = defer_q + DW'(1);
        end else begin
            defer_d = defer_q;
        end
        // Writes to x0 are squashed to the idle pattern.
        if (sel_v && (sel_dest != 5'd0)) begin
            wr_en_d = 1'b1;
            dest_d  = sel_dest;
            data_d  = sel_data;
        end else begin
            wr_en_d = 1'b0;
            dest_d  = '0;
            data_d  = '0;
        end
    end

    // Build the pending-write mask from the live FIFO entries, walking from the head.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                busy_mask[mem_dest_q[rd_ptr_q + AW'(i)]] = 1'b1;
            end
        end
        busy_mask[0] = 1'b0;
    end

    // FIFO storage. The contents are only meaningful below count_q, so this storage has no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_dest_q[wr_ptr_q] <= bus.i_lsu_dest;
            mem_data_q[wr_ptr_q] <= bus.i_lsu_data;
        end
    end

    // State registers. An asynchronous reset drops every buffered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            defer_q  <= '0;
            wr_en_q  <= 1'b0;
            dest_q   <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            defer_q  <= defer_d;
            wr_en_q  <= wr_en_d;
            dest_q   <= dest_d;
            data_q   <= data_d;
        end
    end

    assign bus.o_lsu_ready  = !fifo_full;
    assign bus.o_stall_alu  = stall;
    assign bus.o_busy_mask  = busy_mask;
    assign bus.o_fifo_count = count_q;
    assign bus.o_wr_en      = wr_en_q;
    assign bus.o_dest_addr  = dest_q;
    assign bus.o_data       = data_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter.
// A queue-based reference model predicts every write-port value. A monitor
// compares those predictions one cycle later.
module tb_regfile_wb_arbiter;
  localparam int DEPTH     = 4;
  localparam int MAX_DEFER = 8;
`ifdef WB_LSU_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [4:0]  d;
    logic [31:0] v;
  } ent_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DEPTH(DEPTH)) bus ();
  regfile_wb_arbiter #(.DEPTH(DEPTH), .MAX_DEFER(MAX_DEFER)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [37:0] exp_q[$];
  ent_t mq[$];
  int m_defer = 0;

  // Hold state for the upstream sources
  logic       a_hold = 1'b0;
  logic [4:0] a_hd;
  logic [31:0] a_hx;
  logic       l_hold = 1'b0;
  logic [4:0] l_hd;
  logic [31:0] l_hx;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: compares each registered write against the prediction for it
  initial begin
    logic [37:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wb_port", {bus.o_wr_en, bus.o_dest_addr, bus.o_data}, e);
      end
    end
  end

  // drive one cycle, check status outputs, advance the reference model
  task automatic step(input logic av, input logic [4:0] ad, input logic [31:0] ax,
                      input logic lv, input logic [4:0] ld, input logic [31:0] lx,
                      output logic stalled, output logic taken);
    logic m_stall, m_ready, pre_empty, pop, byp, push, out_v;
    logic [4:0] out_d;
    logic [31:0] out_x, mask;
    ent_t e;
    @(negedge clk);
    bus.i_alu_valid = av; bus.i_alu_dest = ad; bus.i_alu_data = ax;
    bus.i_lsu_valid = lv; bus.i_lsu_dest = ld; bus.i_lsu_data = lx;
    #1;
    pre_empty = (mq.size() == 0);
    m_stall = (m_defer == MAX_DEFER) && !pre_empty;
    m_ready = (mq.size() < DEPTH);
    mask = '0;
    foreach (mq[i]) mask[mq[i].d] = 1'b1;
    mask[0] = 1'b0;
    check("stall", bus.o_stall_alu, m_stall);
    check("ready", bus.o_lsu_ready, m_ready);
    check("count", bus.o_fifo_count, mq.size());
    check("busy_mask", bus.o_busy_mask, mask);
    pop = 1'b0; byp = 1'b0; out_v = 1'b0; out_d = '0; out_x = '0;
    if (m_stall) pop = 1'b1;
    else if (av) begin out_v = 1'b1; out_d = ad; out_x = ax; end
    else if (BYP && pre_empty && lv) begin byp = 1'b1; out_v = 1'b1; out_d = ld; out_x = lx; end
    else if (!pre_empty) pop = 1'b1;
    if (pop) begin
      e = mq.pop_front();
      out_v = 1'b1; out_d = e.d; out_x = e.v;
    end
    push = lv && m_ready && !byp;
    if (push) begin
      e.d = ld; e.v = lx;
      mq.push_back(e);
    end
    if (pre_empty || pop) m_defer = 0;
    else if (m_defer < MAX_DEFER) m_defer++;
    if (out_v && out_d != 5'd0) exp_q.push_back({1'b1, out_d, out_x});
    else exp_q.push_back(38'd0);
    stalled = m_stall;
    taken = byp || push;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    logic s, t;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, s, t);
  endtask

  // reset pulse between clock edges; everything must clear immediately
  task automatic pulse_reset();
    @(negedge clk);
    bus.i_alu_valid = 0; bus.i_lsu_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_wr_en", bus.o_wr_en, 0);
    check("rst_dest", bus.o_dest_addr, 0);
    check("rst_data", bus.o_data, 0);
    check("rst_count", bus.o_fifo_count, 0);
    check("rst_mask", bus.o_busy_mask, 0);
    check("rst_ready", bus.o_lsu_ready, 1);
    check("rst_stall", bus.o_stall_alu, 0);
    mq.delete(); m_defer = 0; exp_q.delete();
    a_hold = 0; l_hold = 0;
    #1 rst_n = 1'b1;
  endtask

  // random traffic with upstream hold rules, alu_pct sets ALU load
  task automatic random_phase(input int cycles, input int alu_pct, input int lsu_pct);
    logic av, lv, s, t;
    logic [4:0] ad, ld;
    logic [31:0] ax, lx;
    for (int i = 0; i < cycles; i++) begin
      if (a_hold) begin av = 1; ad = a_hd; ax = a_hx; end
      else begin
        av = ($urandom_range(0, 99) < alu_pct);
        ad = 5'($urandom_range(0, 31)); ax = $urandom();
      end
      if (l_hold) begin lv = 1; ld = l_hd; lx = l_hx; end
      else begin
        lv = ($urandom_range(0, 99) < lsu_pct);
        ld = 5'($urandom_range(0, 31)); lx = $urandom();
      end
      step(av, ad, ax, lv, ld, lx, s, t);
      a_hold = av && s; a_hd = ad; a_hx = ax;
      l_hold = lv && !t; l_hd = ld; l_hx = lx;
    end
  endtask

  initial begin
    logic s, t;
    int stall_cnt;
    bus.i_alu_valid = 0; bus.i_alu_dest = 0; bus.i_alu_data = 0;
    bus.i_lsu_valid = 0; bus.i_lsu_dest = 0; bus.i_lsu_data = 0;
    #12;
    check("init_wr_en", bus.o_wr_en, 0);
    check("init_count", bus.o_fifo_count, 0);
    check("init_ready", bus.o_lsu_ready, 1);
    #1 rst_n = 1'b1;
    idle(2);

    // reset mid-stream: three buffered results are discarded
    for (int i = 0; i < 3; i++) step(1, 5'(i + 1), $urandom(), 1, 5'(20 + i), $urandom(), s, t);
    check("pre_rst_count", bus.o_fifo_count, 3);
    pulse_reset();
    idle(6);

    // ALU priority
    step(1, 5, 32'h11111111, 1, 6, 32'h22222222, s, t);
    idle(3);

    // x0 squash
    step(1, 0, 32'hDEADBEEF, 0, 0, 0, s, t);
    idle(2);

    // FIFO full then a fifth offer that must be held
    for (int i = 0; i < 4; i++) step(1, 5'(i + 1), $urandom(), 1, 5'(7 + i), $urandom(), s, t);
    check("full_ready", bus.o_lsu_ready, 0);
    check("full_count", bus.o_fifo_count, 4);
    check("full_mask", bus.o_busy_mask, 32'h00000780);
    step(1, 2, $urandom(), 1, 11, 32'hABCD0011, s, t);
    check("fifth_held", t, 0);
    check("fifth_count", bus.o_fifo_count, 4);
    l_hold = 1; l_hd = 11; l_hx = 32'hABCD0011;
    random_phase(1, 0, 0);
    idle(8);

    // starvation: one buffered entry under continuous ALU traffic
    step(1, 1, $urandom(), 1, 9, 32'h99990009, s, t);
    stall_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(1, 5'($urandom_range(1, 31)), $urandom(), 0, 0, 0, s, t);
      if (s) stall_cnt++;
    end
    check("starve_stalls", stall_cnt, 1);
    check("starve_count", bus.o_fifo_count, 0);
    idle(2);

    // bypass, depending on the build
    step(0, 0, 0, 1, 12, 32'h5A5A5A5A, s, t);
    check("byp_count", bus.o_fifo_count, BYP ? 0 : 1);
    idle(3);

    // randomized traffic under several load mixes
    random_phase(300, 90, 60);
    random_phase(300, 40, 50);
    random_phase(300, 10, 80);
    a_hold = 0; l_hold = 0;
    idle(DEPTH + 4);
    @(posedge clk);
    #3;
    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
